// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared FSM state type, defaults and id-width helper for the 4-phase req/ack source scheduler.
package cdc_hs_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, REQ, DROP} state_t;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_TMO_CYC   = 1024;
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cdc_hs_tx_sched_rr_arb.sv
// cdc_hs_rr_arb: combinational round-robin winner; the pointer advances past the winner on accept.
module cdc_hs_rr_arb
  import cdc_hs_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_gid
);
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_gid;
  always_comb begin
    w_gid = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_valid[(int'(r_ptr) + k) % NREQ]) w_gid = IW'((int'(r_ptr) + k) % NREQ);
  end
  assign o_gid   = w_gid;
  assign o_grant = (i_valid != '0) ? (NREQ'(1) << w_gid) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (i_accept) r_ptr <= (int'(w_gid) == NREQ - 1) ? '0 : w_gid + 1'b1;
endmodule

// File: rtl/cdc_hs_tx_sched.sv
// cdc_hs_tx_sched: round-robin source scheduler for a 4-phase req/ack CDC channel.
// Optional handshake timeout enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_hs_tx_sched
  import cdc_hs_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int TMO_CYC   = DEF_TMO_CYC,
  localparam int IW       = id_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  hs_req,
  input  logic                  hs_ack,
  output logic [WIDTH-1:0]      hs_data,
  output logic [IW-1:0]         hs_id,
  output logic                  busy,
  output logic                  timeout_err
);
  state_t           r_state;
  logic [3:0]       r_setup;
  logic [WIDTH-1:0] r_data;
  logic [IW-1:0]    r_id;
  logic             r_hs_req;
  logic             w_accept;
  logic             w_tmo_hit;
  logic [NREQ-1:0]  w_grant;
  logic [IW-1:0]    w_gid;

  // A stale ack still high in IDLE must fall before a new handshake may start.
  assign w_accept  = (r_state == IDLE) && !hs_ack && (req_valid != '0);
  assign req_ready = w_accept ? w_grant : '0;
  assign hs_req    = r_hs_req;
  assign hs_data   = r_data;
  assign hs_id     = r_id;
  assign busy      = (r_state != IDLE);

  cdc_hs_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_gid    (w_gid)
  );

`ifdef CDC_HS_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_tmo;
  logic          r_tmo_err;
  logic          w_wait;
  assign w_wait      = (r_state == REQ && !hs_ack) || (r_state == DROP && hs_ack);
  assign w_tmo_hit   = w_wait && (r_tmo == TW'(TMO_CYC - 1));
  assign timeout_err = r_tmo_err;
  // Counting only while a phase is stalled makes every phase entry start from zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tmo     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo     <= (w_wait && !w_tmo_hit) ? r_tmo + 1'b1 : '0;
      r_tmo_err <= r_tmo_err | w_tmo_hit;
    end
`else
  assign w_tmo_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_setup  <= '0;
      r_data   <= '0;
      r_id     <= '0;
      r_hs_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_data   <= req_data[w_gid*WIDTH +: WIDTH];
          r_id     <= w_gid;
          r_setup  <= 4'((SETUP_CYC == 0) ? 0 : SETUP_CYC - 1);
          r_state  <= (SETUP_CYC == 0) ? REQ : SETUP;
          r_hs_req <= (SETUP_CYC == 0);
        end
        SETUP: if (r_setup == '0) begin
          r_state  <= REQ;
          r_hs_req <= 1'b1;
        end else r_setup <= r_setup - 1'b1;
        REQ: if (hs_ack || w_tmo_hit) begin
          r_state  <= DROP;
          r_hs_req <= 1'b0;
        end
        DROP: if (!hs_ack || w_tmo_hit) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_hs_tx_sched.sv
// tb_cdc_hs_tx_sched: scoreboard bench for cdc_hs_tx_sched; define CDC_HS_TIMEOUT_EN to also exercise the timeout.
module tb_cdc_hs_tx_sched;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int SC   = 2;
  localparam int TMO  = 16;

  typedef struct {int id; logic [W-1:0] data;} exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic            hs_req;
  logic            hs_ack;
  logic [W-1:0]    hs_data;
  logic [1:0]      hs_id;
  logic            busy;
  logic            timeout_err;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   acc_cyc = 0;
  exp_t expq[$];

  logic ack_en = 1'b0;
  logic ack_force = 1'b0;
  logic ack_force_val = 1'b0;
  int   ack_dly = 4;

  cdc_hs_tx_sched #(.NREQ(NREQ), .WIDTH(W), .SETUP_CYC(SC), .TMO_CYC(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .hs_req      (hs_req),
    .hs_ack      (hs_ack),
    .hs_data     (hs_data),
    .hs_id       (hs_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Destination model: echoes hs_req onto hs_ack after ack_dly cycles.
  initial begin
    int dcnt;
    dcnt = 0;
    hs_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_force) begin
        hs_ack = ack_force_val;
        dcnt = 0;
      end else if (ack_en && hs_req != hs_ack) begin
        dcnt++;
        if (dcnt >= ack_dly) begin
          hs_ack = hs_req;
          dcnt = 0;
        end
      end else dcnt = 0;
    end
  end

  // Monitor: payload stability while busy, and scoreboard check of every accept.
  logic         pv_busy = 1'b0;
  logic [W-1:0] pv_data;
  logic [1:0]   pv_id;
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (!rst_n) pv_busy = 1'b0;
    else begin
      if (pv_busy) begin
        total++;
        if (hs_data !== pv_data || hs_id !== pv_id) begin
          bad++;
          $display("FAIL stable: id=%0d data=%h was id=%0d data=%h", hs_id, hs_data, pv_id, pv_data);
        end
      end
      pv_busy = busy;
      pv_data = hs_data;
      pv_id   = hs_id;
      if ((req_ready & req_valid) != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        total++;
        if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0) begin
          bad++;
          $display("FAIL ready_shape: ready=%b valid=%b", req_ready, req_valid);
        end
        acc_cyc = cyc;
        n_acc++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_accept: got id %0d, none expected", g);
        end else begin
          e = expq.pop_front();
          total++;
          if (g != e.id) begin
            bad++;
            $display("FAIL grant: got %0d want %0d", g, e.id);
          end
          @(posedge clk);
          #1;
          total++;
          if (hs_id !== 2'(e.id) || hs_data !== e.data) begin
            bad++;
            $display("FAIL latch: id=%0d data=%h want id=%0d data=%h", hs_id, hs_data, e.id, e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (n_acc < n && t < 300) begin @(negedge clk); t++; end
    chk("accept_count", 64'(n_acc), 64'(n));
  endtask

  task automatic wait_hs_req(input logic v);
    int t = 0;
    while (hs_req !== v && t < 300) begin @(negedge clk); t++; end
    chk("hs_req_wait", 64'(hs_req), 64'(v));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 300) begin @(negedge clk); t++; end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic drive(input logic [NREQ-1:0] v);
    @(posedge clk);
    #1;
    req_valid = v;
  endtask

  logic [W-1:0] tbl [NREQ] = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs_req", 64'(hs_req), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_hs_data", 64'(hs_data), 0);
    chk("rst_hs_id", 64'(hs_id), 0);
    chk("rst_tmo", 64'(timeout_err), 0);
    chk("rst_ready", 64'(req_ready), 0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    ack_dly = 4;

    req_data[2*W +: W] = 32'hCAFE_F00D;
    expq.push_back('{2, 32'hCAFE_F00D});
    drive(4'b0100);
    wait_acc(1);
    drive(4'b0000);
    wait_hs_req(1'b1);
    chk("setup_delay", 64'(cyc - acc_cyc), 64'(SC + 1));
    wait_idle();
    chk("single_hs_req_low", 64'(hs_req), 0);
    chk("single_hs_id_hold", 64'(hs_id), 2);

    ack_en = 1'b0;
    req_data[1*W +: W] = 32'h1111_1111;
    expq.push_back('{1, 32'h1111_1111});
    drive(4'b0010);
    wait_acc(2);
    drive(4'b0000);
    wait_hs_req(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hs_req", 64'(hs_req), 0);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_hs_data", 64'(hs_data), 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    ack_en = 1'b1;
    ack_dly = 2;

    for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = tbl[i];
    for (int k = 0; k < 8; k++) expq.push_back('{k % NREQ, tbl[k % NREQ]});
    drive(4'b1111);
    wait_acc(10);
    drive(4'b0000);
    wait_idle();
    chk("rr_queue_empty", 64'(expq.size()), 0);

    ack_en = 1'b0;
    ack_force = 1'b1;
    ack_force_val = 1'b1;
    req_data[0 +: W] = 32'h5A5A_5A5A;
    expq.push_back('{0, 32'h5A5A_5A5A});
    repeat (2) @(posedge clk);
    drive(4'b0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stale_ack_block", 64'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    ack_force_val = 1'b0;
    @(negedge clk);
    chk("stale_ack_release", 64'(req_ready), 64'b0001);
    wait_acc(11);
    drive(4'b0000);
    ack_force = 1'b0;
    ack_en = 1'b1;
    wait_idle();

`ifdef CDC_HS_TIMEOUT_EN
    ack_en = 1'b0;
    req_data[2*W +: W] = 32'h7777_7777;
    expq.push_back('{2, 32'h7777_7777});
    drive(4'b0100);
    wait_acc(12);
    drive(4'b0000);
    wait_hs_req(1'b1);
    r = cyc;
    for (int t = 0; t < 100 && timeout_err !== 1'b1; t++) @(negedge clk);
    chk("tmo_flag", 64'(timeout_err), 1);
    chk("tmo_cycles", 64'(cyc - r), 64'(TMO));
    chk("tmo_hs_req", 64'(hs_req), 0);
    wait_idle();
    chk("tmo_sticky", 64'(timeout_err), 1);
`else
    r = 0;
    chk("tmo_tied", 64'(timeout_err + r), 0);
`endif
    chk("final_queue_empty", 64'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
